// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - washing-machine phase duration timer
`timescale 1ns/1ps
module wm_phase_timer #(
   parameter int TICK_DIV    = 4,
   parameter int CNT_WIDTH   = 8,
   parameter int SOAK_TICKS  = 5,
   parameter int WASH_TICKS  = 6,
   parameter int RINSE_TICKS = 4,
   parameter int SPIN_TICKS  = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 soak_Operation,
   input  logic                 wash_Operation,
   input  logic                 rinse_Operation,
   input  logic                 spin_Operation,
   input  logic                 lid,
   input  logic                 cancel,
   output logic                 phase_Done,
   output logic [CNT_WIDTH-1:0] time_Left,
   output logic                 running,
   output logic                 paused,
   output logic                 motor_Enable,
   output logic                 drain_Valve,
   output logic                 phase_Error
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]        PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] SOAK_D    = CNT_WIDTH'(SOAK_TICKS);
   localparam logic [CNT_WIDTH-1:0] WASH_D    = CNT_WIDTH'(WASH_TICKS);
   localparam logic [CNT_WIDTH-1:0] RINSE_D   = CNT_WIDTH'(RINSE_TICKS);
   localparam logic [CNT_WIDTH-1:0] SPIN_D    = CNT_WIDTH'(SPIN_TICKS);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE, ST_DONE} state_t;
   typedef enum logic [2:0] {PH_NONE, PH_SOAK, PH_WASH, PH_RINSE, PH_SPIN} phase_t;

   state_t               state_q, state_d;
   phase_t               phase_q, phase_d;
   logic [CNT_WIDTH-1:0] tl_q, tl_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic                 done_q, done_d;
   logic                 running_q, running_d;
   logic                 paused_q, paused_d;
   logic                 motor_q, motor_d;
   logic                 drain_q, drain_d;
   logic                 err_q, err_d;

   logic [3:0]           ops;
   logic                 multi_hot;
   phase_t               ph_in;
   logic                 tick;
   logic [CNT_WIDTH-1:0] load_dur;

   function automatic logic [CNT_WIDTH-1:0] duration(input phase_t p);
      case (p)
         PH_SOAK:  duration = SOAK_D;
         PH_WASH:  duration = WASH_D;
         PH_RINSE: duration = RINSE_D;
         PH_SPIN:  duration = SPIN_D;
         default:  duration = '0;
      endcase
   endfunction

   always_comb begin
      ops       = {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
      multi_hot = |(ops & (ops - 4'd1));
      ph_in     = PH_NONE;
      case (ops)
         4'b0001: ph_in = PH_SOAK;
         4'b0010: ph_in = PH_WASH;
         4'b0100: ph_in = PH_RINSE;
         4'b1000: ph_in = PH_SPIN;
         default: ph_in = PH_NONE;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      tl_d     = tl_q;
      presc_d  = presc_q;
      done_d   = 1'b0;
      tick     = (presc_q == PRESC_MAX);
      load_dur = duration(phase_q);

      if (cancel) begin
         state_d = ST_IDLE;
         phase_d = PH_NONE;
         tl_d    = '0;
         presc_d = '0;
      end else if (!multi_hot) begin
         // A multi-hot input freezes everything; only cancel gets through.
         case (state_q)
            ST_IDLE: begin
               if (ph_in != PH_NONE) begin
                  phase_d = ph_in;
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD, ST_RUN, ST_PAUSE: begin
               if (ph_in != phase_q) begin
                  if (ph_in != PH_NONE) begin
                     phase_d = ph_in;
                     state_d = ST_LOAD;
                  end else begin
                     phase_d = PH_NONE;
                     state_d = ST_IDLE;
                     tl_d    = '0;
                     presc_d = '0;
                  end
               end else if (state_q == ST_LOAD) begin
                  tl_d    = load_dur;
                  presc_d = '0;
                  if (load_dur == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (lid && (phase_q == PH_SPIN)) begin
                  state_d = ST_PAUSE;
               end else begin
                  // Resuming from PAUSE counts in the same cycle the lid closes.
                  state_d = ST_RUN;
                  presc_d = tick ? '0 : presc_q + PW'(1);
                  if (tick) begin
                     if (tl_q <= CNT_WIDTH'(1)) begin
                        tl_d    = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                     end else begin
                        tl_d = tl_q - CNT_WIDTH'(1);
                     end
                  end
               end
            end
            ST_DONE: begin
               if (ph_in != phase_q) begin
                  if (ph_in != PH_NONE) begin
                     phase_d = ph_in;
                     state_d = ST_LOAD;
                  end else begin
                     phase_d = PH_NONE;
                     state_d = ST_IDLE;
                     tl_d    = '0;
                     presc_d = '0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               phase_d = PH_NONE;
               tl_d    = '0;
               presc_d = '0;
            end
         endcase
      end

      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSE);
      motor_d   = (state_d == ST_RUN) &&
                  ((phase_d == PH_WASH) || (phase_d == PH_RINSE) || (phase_d == PH_SPIN));
      drain_d   = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                  ((phase_d == PH_SPIN) || (phase_d == PH_RINSE));
      err_d     = multi_hot;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_NONE;
         tl_q      <= '0;
         presc_q   <= '0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         motor_q   <= 1'b0;
         drain_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         tl_q      <= tl_d;
         presc_q   <= presc_d;
         done_q    <= done_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         motor_q   <= motor_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
      end
   end

   assign phase_Done   = done_q;
   assign time_Left    = tl_q;
   assign running      = running_q;
   assign paused       = paused_q;
   assign motor_Enable = motor_q;
   assign drain_Valve  = drain_q;
   assign phase_Error  = err_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - directed bench for wm_phase_timer
`timescale 1ns/1ps
module tb_wm_phase_timer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       soak_Operation, wash_Operation, rinse_Operation, spin_Operation;
   logic       lid, cancel;
   logic       phase_Done;
   logic [7:0] time_Left;
   logic       running, paused, motor_Enable, drain_Valve, phase_Error;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   wm_phase_timer dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .soak_Operation  (soak_Operation),
      .wash_Operation  (wash_Operation),
      .rinse_Operation (rinse_Operation),
      .spin_Operation  (spin_Operation),
      .lid             (lid),
      .cancel          (cancel),
      .phase_Done      (phase_Done),
      .time_Left       (time_Left),
      .running         (running),
      .paused          (paused),
      .motor_Enable    (motor_Enable),
      .drain_Valve     (drain_Valve),
      .phase_Error     (phase_Error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (phase_Done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      {soak_Operation, wash_Operation, rinse_Operation, spin_Operation} = 4'b0;
      lid = 1'b0;
      cancel = 1'b0;
      #12;
      check("rst_time_left", time_Left, 0);
      check("rst_flags", {phase_Done, running, paused, motor_Enable, drain_Valve, phase_Error}, 0);

      // Wash from release; lid held open has no effect outside spin
      wash_Operation = 1'b1;
      reset_n = 1'b1;
      step(1);
      check("wash_load_tl", time_Left, 0);
      check("wash_load_run", running, 0);
      step(1);
      check("wash_tl6", time_Left, 6);
      check("wash_running", running, 1);
      check("wash_motor", motor_Enable, 1);
      check("wash_drain", drain_Valve, 0);
      lid = 1'b1;
      step(3);
      check("wash_e5_tl", time_Left, 6);
      step(1);
      check("wash_e6_tl", time_Left, 5);
      step(19);
      check("wash_e25_tl", time_Left, 1);
      check("wash_e25_done", phase_Done, 0);
      check("wash_e25_motor", motor_Enable, 1);
      check("wash_e25_paused", paused, 0);
      step(1);
      check("wash_e26_done", phase_Done, 1);
      check("wash_e26_tl", time_Left, 0);
      check("wash_e26_run", running, 0);
      check("wash_e26_motor", motor_Enable, 0);
      lid = 1'b0;
      step(1);
      check("wash_e27_done", phase_Done, 0);
      step(1);
      check("wash_no_rearm", {phase_Done, running}, 0);
      check("wash_done_cnt", done_cnt, 1);
      wash_Operation = 1'b0;
      step(2);

      // Spin with a 10-cycle lid-open pause
      spin_Operation = 1'b1;
      step(2);
      check("spin_tl3", time_Left, 3);
      check("spin_motor_drain", {motor_Enable, drain_Valve}, 2'b11);
      step(4);
      check("spin_e6_tl", time_Left, 2);
      lid = 1'b1;
      step(1);
      check("spin_paused", {running, paused}, 2'b01);
      check("spin_pause_motor", motor_Enable, 0);
      check("spin_pause_drain", drain_Valve, 1);
      check("spin_pause_tl", time_Left, 2);
      step(9);
      check("spin_e16_paused", paused, 1);
      check("spin_e16_tl", time_Left, 2);
      lid = 1'b0;
      step(1);
      check("spin_resume", {running, paused, motor_Enable}, 3'b101);
      check("spin_e17_tl", time_Left, 2);
      step(3);
      check("spin_e20_tl", time_Left, 1);
      step(3);
      check("spin_e23_done", phase_Done, 0);
      step(1);
      check("spin_e24_done", phase_Done, 1);
      check("spin_e24_tl", time_Left, 0);
      spin_Operation = 1'b0;
      step(1);
      check("spin_done_cnt", done_cnt, 2);
      step(1);

      // Rinse cancelled at time_Left == 2
      rinse_Operation = 1'b1;
      step(2);
      check("rinse_tl4", time_Left, 4);
      check("rinse_outs", {motor_Enable, drain_Valve}, 2'b11);
      step(9);
      check("rinse_e11_tl", time_Left, 2);
      cancel = 1'b1;
      step(1);
      check("cancel_tl", time_Left, 0);
      check("cancel_outs", {running, motor_Enable, drain_Valve, phase_Done}, 0);
      step(1);
      check("cancel_held", {running, time_Left}, 0);
      cancel = 1'b0;
      step(1);
      check("recan_load", running, 0);
      step(1);
      check("recan_tl4", time_Left, 4);
      check("recan_run", running, 1);
      check("cancel_done_cnt", done_cnt, 2);
      rinse_Operation = 1'b0;
      step(1);
      check("abort_tl", time_Left, 0);
      check("abort_outs", {running, drain_Valve, phase_Done}, 0);
      step(1);

      // Multi-hot inputs: blocked load, then frozen counters mid-run
      wash_Operation = 1'b1;
      rinse_Operation = 1'b1;
      step(1);
      check("mh_err", phase_Error, 1);
      check("mh_noload", {running, time_Left}, 0);
      step(1);
      check("mh_err2", phase_Error, 1);
      rinse_Operation = 1'b0;
      step(1);
      check("mh_clear", phase_Error, 0);
      check("mh_load", running, 0);
      step(1);
      check("mh_tl6", time_Left, 6);
      step(2);
      rinse_Operation = 1'b1;
      step(1);
      check("mh_run_err", phase_Error, 1);
      check("mh_run_hold", running, 1);
      step(3);
      check("mh_e10_tl", time_Left, 6);
      rinse_Operation = 1'b0;
      step(1);
      check("mh_e11", {phase_Error, time_Left}, 6);
      step(1);
      check("mh_e12_tl", time_Left, 5);
      wash_Operation = 1'b0;
      step(2);

      // Soak completes, controller hands over to wash in the DONE cycle
      soak_Operation = 1'b1;
      step(2);
      check("soak_tl5", time_Left, 5);
      check("soak_motor", motor_Enable, 0);
      step(20);
      check("soak_done", phase_Done, 1);
      soak_Operation = 1'b0;
      wash_Operation = 1'b1;
      step(1);
      check("handover_load", {phase_Done, running, time_Left}, 0);
      step(1);
      check("handover_tl6", time_Left, 6);
      check("handover_run", running, 1);
      check("handover_done_cnt", done_cnt, 3);
      wash_Operation = 1'b0;
      step(2);

      // Asynchronous reset mid-run, then full reload
      soak_Operation = 1'b1;
      step(8);
      check("soak_e8_tl", time_Left, 4);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_tl", time_Left, 0);
      check("async_rst_run", running, 0);
      #2;
      reset_n = 1'b1;
      step(1);
      check("post_rst_load", {running, time_Left}, 0);
      step(1);
      check("post_rst_tl5", time_Left, 5);
      step(19);
      check("post_rst_e21", {phase_Done, time_Left}, 1);
      step(1);
      check("post_rst_done", phase_Done, 1);
      soak_Operation = 1'b0;
      step(2);
      check("final_done_cnt", done_cnt, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
Phase-duration timer placed directly downstream of the washing-machine controller FSM. It consumes the controller's one-hot operation outputs (soak/wash/rinse/spin), loads a per-phase duration, and counts it down on a prescaled tick. It returns a one-cycle phase_Done pulse that the controller uses to advance states, and it drives the motor and drain actuators. It pauses on an open lid during spin and aborts on cancel.

Parameters:
TICK_DIV, 4, clock cycles per timer tick (>=2)
CNT_WIDTH, 8, width of tick counter / time_Left
SOAK_TICKS, 5, soak duration in ticks
WASH_TICKS, 6, wash duration in ticks
RINSE_TICKS, 4, rinse duration in ticks
SPIN_TICKS, 3, spin duration in ticks

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
soak_Operation  input  1  controller in SOAK
wash_Operation  input  1  controller in WASH
rinse_Operation  input  1  controller in RINSE
spin_Operation  input  1  controller in SPIN
lid  input  1  1 = lid open
cancel  input  1  abort request, level
phase_Done  output  1  one-cycle pulse, phase duration elapsed
time_Left  output  CNT_WIDTH  remaining ticks of current phase
running  output  1  state RUN
paused  output  1  state PAUSE
motor_Enable  output  1  drum motor on
drain_Valve  output  1  drain open
phase_Error  output  1  more than one operation input high

Behaviour:
- Reset (reset_n low, async): state IDLE. All outputs 0, time_Left 0, prescaler 0, latched phase NONE.
- All outputs are registered.
- Phase decode: exactly one operation input high gives a valid phase (SOAK/WASH/RINSE/SPIN). None high gives NONE. Two or more high gives an error.
- phase_Error = registered multi-hot flag, updated every cycle. While it is set, the FSM takes no transitions other than cancel, counters hold, and phase_Done stays 0.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: on a valid phase, latch the phase and go to LOAD.
- LOAD (1 cycle): time_Left <= duration of the latched phase; prescaler <= 0.
  - If duration != 0, go to RUN.
  - If duration == 0, go to DONE and pulse phase_Done.
- RUN: prescaler increments each cycle and wraps at TICK_DIV-1.
  - On wrap, time_Left decrements.
  - On the wrap where time_Left == 1: time_Left <= 0, phase_Done <= 1 for one cycle, go to DONE.
  - Total RUN residency = duration*TICK_DIV cycles.
- PAUSE: entered from RUN when lid == 1 and the latched phase is SPIN. Prescaler and time_Left hold. When lid == 0, return to RUN and continue from the held prescaler value. lid has no effect in other phases.
- DONE: hold until the latched phase input drops.
  - Drops to NONE: go to IDLE.
  - A different valid phase asserted in the same cycle: latch it and go to LOAD.
  - Done is not re-armed while the same phase stays high.
- Phase change mid-operation (in LOAD/RUN/PAUSE the latched input drops or a different phase is asserted): abort with no phase_Done pulse. Go to LOAD with the new phase if one is valid, otherwise IDLE with time_Left cleared.
- cancel: highest priority, any state. The next state is IDLE, time_Left 0, prescaler 0, no pulse. Held cancel keeps the block in IDLE.
- Outputs:
  - running = (state == RUN); paused = (state == PAUSE).
  - motor_Enable = RUN and latched phase is WASH, RINSE or SPIN.
  - drain_Valve = (RUN or PAUSE) and latched phase is SPIN or RINSE.
- Arithmetic: time_Left never decrements below 0. Durations are truncated to CNT_WIDTH; parameter values above 2^CNT_WIDTH-1 are illegal.
- Reset mid-phase: immediate return to the reset state. Controller re-entry then restarts the full duration.

Test Plan:
- Defaults; wash_Operation high from cycle 0 -> LOAD at edge 1, time_Left=6 and running=1 from edge 2. Decrements every 4 cycles. phase_Done high exactly one cycle at edge 26 with time_Left=0. motor_Enable high edges 2–25.
- spin_Operation high; lid=1 for 10 cycles after 5 RUN cycles -> paused=1, time_Left and motor_Enable frozen (motor 0). After lid=0, phase_Done arrives 10 cycles later than the 12-cycle nominal.
- cancel pulsed mid-RUN of rinse (time_Left=2) -> next edge IDLE, time_Left=0, running=0. phase_Done is never asserted. Deassert cancel with rinse still high -> reload to 4.
- wash and rinse high together -> phase_Error=1, no load, time_Left holds. Drop rinse -> phase_Error=0, LOAD wash.
- soak completes; controller switches soak->wash in the DONE cycle -> LOAD directly, time_Left=6, only one phase_Done seen.
- reset_n low asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. Release with soak high -> full 5-tick reload.
